// File: rtl/vec_reduce_unit.sv
// Multi-cycle FP32 vector reduction (SUM / MAX / MIN) over WIDTH/LANES beats.
// Elements are IEEE-754 single-precision bit patterns, packed element 0 in the LSBs.
module vec_reduce_unit #(
  parameter int WIDTH           = 128,
  parameter int LANES           = 8,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic [WIDTH*32-1:0]        vec_in,
  output logic                       busy,
  output logic                       done,
  input  logic                       ack,
  output logic [31:0]                result,
  output logic [WIDTH_ADDR_SIZE-1:0] result_idx
);

  localparam int DATA_W = 32;
  localparam int BEATS  = WIDTH / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] OP_SUM = 2'b00;
  localparam logic [1:0] OP_MAX = 2'b01;
  localparam logic [1:0] OP_MIN = 2'b10;

  if (WIDTH % LANES != 0) begin : g_bad_lanes
    $fatal(1, "vec_reduce_unit: WIDTH must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                     state;
  logic [BEAT_W-1:0]          beat;
  logic [DATA_W-1:0]          snap_p0 [WIDTH];
  logic [1:0]                 op_p0;
  logic [DATA_W-1:0]          acc_p1;
  logic [WIDTH_ADDR_SIZE-1:0] idx_p1;
  logic [DATA_W-1:0]          acc_n;
  logic [WIDTH_ADDR_SIZE-1:0] idx_n;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] x);
    return x[30:0] == 31'h7F80_0000;
  endfunction

  // Round-to-nearest-even on a 24-bit significand carrying guard/round/sticky bits.
  function automatic logic [31:0] fp_round_pack(input logic sgn, input int e,
                                                input logic [26:0] m);
    logic        rnd;
    logic [24:0] mr;
    int          eo;
    eo  = e;
    rnd = m[2] && (m[1] || m[0] || m[3]);
    mr  = {1'b0, m[26:3]} + 25'(rnd);
    if (mr[24]) begin
      mr = mr >> 1;
      eo = eo + 1;
    end
    if (eo >= 255) return {sgn, 8'hFF, 23'h0};
    return {sgn, (mr[23] ? 8'(eo) : 8'h00), mr[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [26:0] mx, my, sh;
    logic [27:0] s;
    logic        sticky;
    int          ex, ey, eo, d;
    if (fp_is_nan(a)) return a | 32'h0040_0000;
    if (fp_is_nan(b)) return b | 32'h0040_0000;
    if (fp_is_inf(a) && fp_is_inf(b) && (a[31] != b[31])) return 32'h7FC0_0000;
    if (fp_is_inf(a)) return a;
    if (fp_is_inf(b)) return b;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    ex = (x[30:23] == 8'h00) ? 1 : int'(x[30:23]);
    ey = (y[30:23] == 8'h00) ? 1 : int'(y[30:23]);
    mx = {(x[30:23] != 8'h00), x[22:0], 3'b000};
    my = {(y[30:23] != 8'h00), y[22:0], 3'b000};
    d  = ex - ey;
    if (d >= 27) begin
      my = {26'b0, (my != 27'h0)};
    end else begin
      sh     = my >> d;
      sticky = |(my & ((27'h1 << d) - 27'h1));
      my     = sh | {26'b0, sticky};
    end
    eo = ex;
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, my};
      if (s[27]) begin
        s  = {1'b0, s[27:2], s[1] | s[0]};
        eo = eo + 1;
      end
    end else begin
      s = {1'b0, mx - my};
      if (s == 28'h0) return 32'h0000_0000;
      for (int i = 0; i < 26; i++) begin
        if (!s[26] && eo > 1) begin
          s  = s << 1;
          eo = eo - 1;
        end
      end
    end
    return fp_round_pack(x[31], eo, s[26:0]);
  endfunction

  // Ordered compare; any NaN operand yields false and +0 equals -0.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ka, kb;
    if (fp_is_nan(a) || fp_is_nan(b)) return 1'b0;
    if (((a | b) & 32'h7FFF_FFFF) == 32'h0) return 1'b0;
    ka = a[31] ? ~a : (a | 32'h8000_0000);
    kb = b[31] ? ~b : (b | 32'h8000_0000);
    return ka > kb;
  endfunction

  // Fold one beat of LANES elements in ascending index order.
  always_comb begin
    logic [WIDTH_ADDR_SIZE-1:0] eidx;
    logic [DATA_W-1:0]          e;
    acc_n = acc_p1;
    idx_n = idx_p1;
    eidx  = '0;
    e     = '0;
    for (int l = 0; l < LANES; l++) begin
      eidx = WIDTH_ADDR_SIZE'(int'(beat) * LANES + l);
      e    = snap_p0[eidx];
      case (op_p0)
        OP_SUM: acc_n = fp_add(acc_n, e);
        OP_MAX: if (fp_gt(e, acc_n)) begin
          acc_n = e;
          idx_n = eidx;
        end
        OP_MIN: if (fp_gt(acc_n, e)) begin
          acc_n = e;
          idx_n = eidx;
        end
        default: begin
          acc_n = '0;
          idx_n = '0;
        end
      endcase
    end
  end

  // p0: snapshot on accepted start; p1: accumulator advanced once per beat.
  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < WIDTH; i++) begin
        snap_p0[i] <= vec_in[i*DATA_W +: DATA_W];
      end
      op_p0  <= op;
      acc_p1 <= (op == OP_SUM) ? '0 : vec_in[DATA_W-1:0];
      idx_p1 <= '0;
    end else if (state == BUSY) begin
      acc_p1 <= acc_n;
      idx_p1 <= idx_n;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      beat       <= '0;
      result     <= '0;
      result_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= BUSY;
          busy  <= 1'b1;
          beat  <= '0;
        end
        BUSY: if (beat == BEAT_W'(BEATS - 1)) begin
          state      <= DONE;
          busy       <= 1'b0;
          done       <= 1'b1;
          beat       <= '0;
          result     <= acc_n;
          result_idx <= idx_n;
        end else begin
          beat <= beat + BEAT_W'(1);
        end
        DONE: if (ack) begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
